// File: rtl/branch_history_checkpoint_pkg.sv
// Shared branch-history types and TAGE fold geometry.
// Imported by the checkpoint ring and the decode-side history update.
package branch_history_checkpoint_pkg;

   localparam int DEPTH          = 8;
   localparam int ID_W           = $clog2(DEPTH);
   localparam int PTR_W          = ID_W + 1;
   localparam int GHR_LEN        = 64;
   localparam int TAGE_TABLE_NUM = 8;
   localparam int TAGE_TABLE_LEN = 256;
   localparam int TAGE_IDX_W     = $clog2(TAGE_TABLE_LEN);
   localparam int TAGE_TAG_WIDTH = 7;
   localparam int TAGE_TAG2_W    = TAGE_TAG_WIDTH - 1;
   localparam int TAGE_ENTRY_W   = TAGE_IDX_W + TAGE_TAG_WIDTH
                                 + TAGE_TAG2_W;
   localparam int FOLD_W         = TAGE_TABLE_NUM * TAGE_ENTRY_W;

   // Roughly geometric history lengths; the longest uses the full GHR.
   function automatic int tage_hist(input int t);
      case (t)
         0:       return 4;
         1:       return 6;
         2:       return 10;
         3:       return 16;
         4:       return 24;
         5:       return 32;
         6:       return 48;
         default: return 64;
      endcase
   endfunction

   function automatic int csr_w(input int k);
      case (k)
         0:       return TAGE_IDX_W;
         1:       return TAGE_TAG_WIDTH;
         default: return TAGE_TAG2_W;
      endcase
   endfunction

   function automatic int csr_off(input int k);
      case (k)
         0:       return 0;
         1:       return TAGE_IDX_W;
         default: return TAGE_IDX_W + TAGE_TAG_WIDTH;
      endcase
   endfunction

   typedef struct packed {
      logic [GHR_LEN-1:0] ghr;
      logic [FOLD_W-1:0]  fold;
      logic               color;
   } checkpoint_t;

endpackage

// File: rtl/branch_history_checkpoint_if.sv
// Decode/execute/commit side bundle of the branch checkpoint ring.
interface branch_history_checkpoint_if;
   import branch_history_checkpoint_pkg::*;

   logic              alloc_valid;
   logic [GHR_LEN-1:0] alloc_ghr;
   logic [FOLD_W-1:0] alloc_fold;
   logic              alloc_ready;
   logic [ID_W-1:0]   alloc_id;
   logic              alloc_color;
   logic              resolve_valid;
   logic              resolve_mispredict;
   logic [ID_W-1:0]   resolve_id;
   logic              resolve_color;
   logic              resolve_outcome;
   logic              commit_valid;
   logic              recover_valid;
   logic [GHR_LEN-1:0] recover_ghr;
   logic [FOLD_W-1:0] recover_fold;
   logic [PTR_W-1:0]  count;
   logic              empty;

   modport master (
      output alloc_valid, alloc_ghr, alloc_fold,
      output resolve_valid, resolve_mispredict, resolve_id,
      output resolve_color, resolve_outcome, commit_valid,
      input  alloc_ready, alloc_id, alloc_color,
      input  recover_valid, recover_ghr, recover_fold,
      input  count, empty
   );

   modport slave (
      input  alloc_valid, alloc_ghr, alloc_fold,
      input  resolve_valid, resolve_mispredict, resolve_id,
      input  resolve_color, resolve_outcome, commit_valid,
      output alloc_ready, alloc_id, alloc_color,
      output recover_valid, recover_ghr, recover_fold,
      output count, empty
   );

endinterface

// File: rtl/branch_history_checkpoint_fold.sv
// One-bit shift of every folded TAGE CSR (idx, tag, tag2 per table).
module tage_fold_update
   import branch_history_checkpoint_pkg::*;
(
   input  logic [FOLD_W-1:0]  fold_i,
   input  logic [GHR_LEN-1:0] ghr_i,
   input  logic               bit_i,
   output logic [FOLD_W-1:0]  fold_o
);

   for (genvar t = 0; t < TAGE_TABLE_NUM; t++) begin : g_tbl
      localparam int L = tage_hist(t);
      for (genvar k = 0; k < 3; k++) begin : g_csr
         localparam int W   = csr_w(k);
         localparam int OFF = t * TAGE_ENTRY_W + csr_off(k);
         logic [W:0] sh;
         // Shift in the new bit, cancel the bit aging out of the window.
         assign sh = {fold_i[OFF +: W], bit_i}
                   ^ ({{W{1'b0}}, ghr_i[L-1]} << (L % W));
         assign fold_o[OFF +: W] = {sh[W-1:1], sh[0] ^ sh[W]};
      end
   end

endmodule

// File: rtl/branch_history_checkpoint.sv
// Speculative branch-history checkpoint ring with one-cycle recovery.
module branch_history_checkpoint
   import branch_history_checkpoint_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   branch_history_checkpoint_if.slave  bus
);

   logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
   logic [DEPTH-1:0]   valid_q, valid_d;
   checkpoint_t        ring_q [DEPTH];
   logic               rec_valid_q;
   logic [GHR_LEN-1:0] rec_ghr_q, rec_ghr_d;
   logic [FOLD_W-1:0]  rec_fold_q, rec_fold_d;

   logic [PTR_W-1:0]   count_w;
   logic [ID_W-1:0]    offs;
   logic [FOLD_W-1:0]  fold_fix;
   checkpoint_t        snap;
   logic               full, res_act, mispredict;
   logic               alloc_fire, commit_fire;

   assign count_w     = tail_q - head_q;
   assign full        = count_w == PTR_W'(DEPTH);
   assign snap        = ring_q[bus.resolve_id];
   // Stale resolves from squashed laps carry the wrong color.
   assign res_act     = bus.resolve_valid & valid_q[bus.resolve_id]
                      & (snap.color == bus.resolve_color);
   assign mispredict  = res_act & bus.resolve_mispredict;
   assign alloc_fire  = bus.alloc_valid & ~full;
   assign commit_fire = bus.commit_valid & (count_w != '0);

   tage_fold_update u_fold (
      .fold_i (snap.fold),
      .ghr_i  (snap.ghr),
      .bit_i  (bus.resolve_outcome),
      .fold_o (fold_fix)
   );

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      valid_d    = valid_q;
      rec_ghr_d  = rec_ghr_q;
      rec_fold_d = rec_fold_q;
      offs       = '0;
      if (mispredict) begin
         tail_d = {bus.resolve_color, bus.resolve_id} + PTR_W'(1);
         for (int i = 0; i < DEPTH; i++) begin
            offs = ID_W'(i) - head_q[ID_W-1:0];
            if ({1'b0, offs} >= tail_d - head_q) valid_d[i] = 1'b0;
         end
         rec_ghr_d  = {snap.ghr[GHR_LEN-2:0], bus.resolve_outcome};
         rec_fold_d = fold_fix;
      end else if (alloc_fire) begin
         tail_d = tail_q + PTR_W'(1);
         valid_d[tail_q[ID_W-1:0]] = 1'b1;
      end
      if (commit_fire) begin
         head_d = head_q + PTR_W'(1);
         valid_d[head_q[ID_W-1:0]] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q      <= '0;
         tail_q      <= '0;
         valid_q     <= '0;
         rec_valid_q <= 1'b0;
         rec_ghr_q   <= '0;
         rec_fold_q  <= '1;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         valid_q     <= valid_d;
         rec_valid_q <= mispredict;
         rec_ghr_q   <= rec_ghr_d;
         rec_fold_q  <= rec_fold_d;
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_fire && !mispredict) begin
         ring_q[tail_q[ID_W-1:0]] <= '{ghr:   bus.alloc_ghr,
                                       fold:  bus.alloc_fold,
                                       color: tail_q[ID_W]};
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (count_w <= PTR_W'(DEPTH));
         if (mispredict)
            assert (({bus.resolve_color, bus.resolve_id} - head_q)
                    < count_w);
      end
   end
`endif

   assign bus.alloc_ready   = ~full;
   assign bus.alloc_id      = tail_q[ID_W-1:0];
   assign bus.alloc_color   = tail_q[ID_W];
   assign bus.recover_valid = rec_valid_q;
   assign bus.recover_ghr   = rec_ghr_q;
   assign bus.recover_fold  = rec_fold_q;
   assign bus.count         = count_w;
   assign bus.empty         = count_w == '0;

endmodule
